nes_oam_dma: RTL and testbench

Sprite (OAM) DMA engine on the NES CPU bus. A CPU write of page number P to $4014 makes this block take ownership of the CPU-side address bus. It then copies the 256 bytes at $PP00-$PPFF into the PPU OAM data port $2004, using alternating read (get) and write (put) cycles. While it runs, its address and strobes are multiplexed ahead of the CPU's, so they reach the cartridge mapper's prg_ain/prg_read/prg_write and the PPU register decode exactly as CPU accesses would.

---
 rtl/nes_bus_pkg.sv | 16 +
 rtl/nes_oam_dma.sv | 103 ++++++++++
 tb/tb_nes_oam_dma.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/nes_bus_pkg.sv
// Shared NES CPU-bus definitions: register addresses used by the PPU/APU decoders
// and the sprite DMA engine, plus the DMA state encoding.
package nes_bus_pkg;

   localparam logic [15:0] OAM_DMA_ADDR     = 16'h4014;
   localparam logic [15:0] PPU_OAMDATA_ADDR = 16'h2004;

   typedef enum logic [2:0] {
      StIdle,
      StHalt,
      StAlign,
      StGet,
      StPut
   } oam_dma_state_t;

endpackage

// File: rtl/nes_oam_dma.sv
// Sprite DMA: a CPU write of page P to $4014 copies $PP00-$PPFF into $2004 using
// alternating get/put cycles while holding the CPU off the bus.
module nes_oam_dma
   import nes_bus_pkg::*;
#(
   parameter logic [15:0] TRIGGER_ADDR  = OAM_DMA_ADDR,
   parameter logic [15:0] OAM_DATA_ADDR = PPU_OAMDATA_ADDR
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_ce,
   input  logic [15:0] i_cpu_ain,
   input  logic [7:0]  i_cpu_dout,
   input  logic        i_cpu_write,
   input  logic [7:0]  i_dma_din,
   output logic        o_dma_active,
   output logic [15:0] o_dma_ain,
   output logic        o_dma_read,
   output logic        o_dma_write,
   output logic [7:0]  o_dma_dout
);

   oam_dma_state_t r_state;
   oam_dma_state_t w_state_next;
   logic           r_put_phase;
   logic [7:0]     r_page;
   logic [7:0]     r_index;
   logic [7:0]     r_latch;
   logic [15:0]    r_ain_hold;
   logic [7:0]     r_dout_hold;
   logic           w_trigger;

   assign w_trigger = i_cpu_write && (i_cpu_ain == TRIGGER_ADDR);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= StIdle;
      end else if (i_ce) begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle:  if (w_trigger) w_state_next = StHalt;
         // r_put_phase is the parity of the current cycle; the next one is a get when it is 1.
         StHalt:  w_state_next = r_put_phase ? StGet : StAlign;
         StAlign: w_state_next = StGet;
         StGet:   w_state_next = StPut;
         StPut:   w_state_next = (r_index == 8'hFF) ? StIdle : StGet;
         default: w_state_next = StIdle;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_put_phase <= 1'b0;
         r_page      <= 8'h00;
         r_index     <= 8'h00;
         r_latch     <= 8'h00;
         r_ain_hold  <= 16'h0000;
         r_dout_hold <= 8'h00;
      end else if (i_ce) begin
         r_put_phase <= ~r_put_phase;
         r_ain_hold  <= o_dma_ain;
         r_dout_hold <= o_dma_dout;
         unique case (r_state)
            StIdle: begin
               if (w_trigger) begin
                  r_page  <= i_cpu_dout;
                  r_index <= 8'h00;
               end
            end
            StGet: r_latch <= i_dma_din;
            // Index wraps inside the page; it never carries into r_page.
            StPut: if (r_index != 8'hFF) r_index <= r_index + 8'h01;
            default: ;
         endcase
      end
   end

   always_comb begin
      o_dma_active = (r_state != StIdle);
      o_dma_read   = 1'b0;
      o_dma_write  = 1'b0;
      o_dma_ain    = r_ain_hold;
      o_dma_dout   = r_dout_hold;
      unique case (r_state)
         StGet: begin
            o_dma_read = 1'b1;
            o_dma_ain  = {r_page, r_index};
         end
         StPut: begin
            o_dma_write = 1'b1;
            o_dma_ain   = OAM_DATA_ADDR;
            o_dma_dout  = r_latch;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_nes_oam_dma.sv
// Directed bench for nes_oam_dma: memory returns low address byte ^ 8'h5A, and every
// ce cycle of each transfer is checked against a hand-derived get/put schedule.
module tb_nes_oam_dma;

   logic        clk = 1'b0;
   logic        reset;
   logic        ce;
   logic [15:0] cpu_ain;
   logic [7:0]  cpu_dout;
   logic        cpu_write;
   logic [7:0]  dma_din;
   logic        dma_active;
   logic [15:0] dma_ain;
   logic        dma_read;
   logic        dma_write;
   logic [7:0]  dma_dout;

   int          n_chk  = 0;
   int          n_fail = 0;
   bit          ph;          // expected put_phase of the current cycle
   logic [15:0] last_ain;    // expected held address outside GET/PUT
   logic [7:0]  last_dout;

   always #5 clk = ~clk;

   assign dma_din = dma_ain[7:0] ^ 8'h5A;

   nes_oam_dma dut (
      .i_clk        (clk),
      .i_reset      (reset),
      .i_ce         (ce),
      .i_cpu_ain    (cpu_ain),
      .i_cpu_dout   (cpu_dout),
      .i_cpu_write  (cpu_write),
      .i_dma_din    (dma_din),
      .o_dma_active (dma_active),
      .o_dma_ain    (dma_ain),
      .o_dma_read   (dma_read),
      .o_dma_write  (dma_write),
      .o_dma_dout   (dma_dout)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input bit act, input bit rd, input bit wr,
                          input logic [15:0] ain, input logic [7:0] dout);
      chk({tag, ".active"}, 32'(dma_active), 32'(act));
      chk({tag, ".read"},   32'(dma_read),   32'(rd));
      chk({tag, ".write"},  32'(dma_write),  32'(wr));
      chk({tag, ".ain"},    32'(dma_ain),    32'(ain));
      chk({tag, ".dout"},   32'(dma_dout),   32'(dout));
   endtask

   task automatic tick(input bit c);
      ce = c;
      @(posedge clk);
      #1;
      if (c) ph = ~ph;
   endtask

   // Trigger so that the trigger cycle parity equals want_align (parity 1 forces ALIGN).
   task automatic trigger(input logic [7:0] page, input bit want_align);
      if (ph != want_align) tick(1'b1);
      cpu_write = 1'b1;
      cpu_ain   = 16'h4014;
      cpu_dout  = page;
      tick(1'b1);
      cpu_write = 1'b0;
      cpu_ain   = 16'h0000;
   endtask

   task automatic xfer(input logic [7:0] page, input bit align, input bit rnd,
                       input int abort_idx, input int stray_step);
      int n;
      int act;
      int t;
      bit e_rd;
      bit e_wr;
      logic [7:0] idx;
      n   = align ? 514 : 513;
      act = 0;
      trigger(page, align);
      for (int s = 0; s < n; s++) begin
         if (s > 0) begin
            if (s == stray_step) begin
               cpu_write = 1'b1;
               cpu_ain   = 16'h4014;
               cpu_dout  = 8'h11;
            end
            tick(1'b1);
            cpu_write = 1'b0;
            cpu_ain   = 16'h0000;
         end
         t    = s - 1 - int'(align);
         idx  = 8'(t / 2);
         e_rd = 1'b0;
         e_wr = 1'b0;
         if (s > 0 && t >= 0) begin
            if (t % 2 == 0) begin
               e_rd     = 1'b1;
               last_ain = {page, idx};
            end else begin
               e_wr      = 1'b1;
               last_ain  = 16'h2004;
               last_dout = idx ^ 8'h5A;
            end
         end
         if (dma_active) act++;
         chk_out($sformatf("p%h.s%0d", page, s), 1'b1, e_rd, e_wr, last_ain, last_dout);
         if (abort_idx >= 0 && t == 2 * abort_idx) begin
            reset = 1'b1;
            tick(1'b0);
            reset     = 1'b0;
            ph        = 1'b0;
            last_ain  = 16'h0000;
            last_dout = 8'h00;
            chk_out("abort", 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
            tick(1'b1);
            chk_out("abort.next", 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
            return;
         end
         if (rnd) begin
            repeat ($urandom_range(0, 2)) begin
               tick(1'b0);
               chk_out($sformatf("p%h.s%0d.ce0", page, s), 1'b1, e_rd, e_wr, last_ain, last_dout);
            end
         end
      end
      tick(1'b1);
      chk_out($sformatf("p%h.end", page), 1'b0, 1'b0, 1'b0, last_ain, last_dout);
      chk($sformatf("p%h.len", page), act, n);
   endtask

   initial begin
      reset     = 1'b1;
      ce        = 1'b1;
      cpu_write = 1'b0;
      cpu_ain   = 16'h0000;
      cpu_dout  = 8'h00;
      tick(1'b1);
      tick(1'b1);
      reset     = 1'b0;
      ph        = 1'b0;
      last_ain  = 16'h0000;
      last_dout = 8'h00;
      chk_out("reset", 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);

      // Non-trigger accesses must leave the engine idle.
      cpu_write = 1'b1;
      cpu_ain   = 16'h4015;
      cpu_dout  = 8'h02;
      tick(1'b1);
      chk("wr4015", 32'(dma_active), 32'd0);
      cpu_write = 1'b0;
      cpu_ain   = 16'h4014;
      tick(1'b1);
      chk("rd4014", 32'(dma_active), 32'd0);
      cpu_write = 1'b1;
      tick(1'b0);
      chk("trig.ce0", 32'(dma_active), 32'd0);
      cpu_write = 1'b0;
      cpu_ain   = 16'h0000;
      tick(1'b1);
      chk("trig.ce0.after", 32'(dma_active), 32'd0);

      xfer(8'h02, 1'b0, 1'b0, -1, -1);
      xfer(8'h02, 1'b1, 1'b0, -1, -1);
      xfer(8'h07, 1'b0, 1'b1, -1, -1);
      xfer(8'h10, 1'b1, 1'b0, 'h40, -1);
      xfer(8'h03, 1'b0, 1'b0, -1, -1);
      xfer(8'hFF, 1'b0, 1'b0, -1, 300);

      // Trigger coinciding with reset: reset wins.
      reset     = 1'b1;
      cpu_write = 1'b1;
      cpu_ain   = 16'h4014;
      cpu_dout  = 8'h05;
      tick(1'b1);
      reset     = 1'b0;
      cpu_write = 1'b0;
      cpu_ain   = 16'h0000;
      ph        = 1'b0;
      chk_out("rst_trig", 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
      tick(1'b1);
      chk_out("rst_trig.next", 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
